// File: rtl/vcu_arbiter_if.sv
// -----------------------------------------------------------------------------
// vcu_arbiter_if
// Bundles the two CPU-side write ports, their status words and the shared VCU
// register port of vcu_arbiter.
//
// Signals (per core pN, N = 0/1):
//   pN_ctrl / pN_ctrl_we     core control data and write strobe
//   pN_wdata / pN_wdata_we   core write data and write strobe
//   pN_rdata                 per-core status word back to the core
// Shared VCU side:
//   vcu_ready                VCU accepts a write at the next edge
//   vcu_reg_control(_we)     forwarded control value and one-cycle pulse
//   vcu_reg_wdata(_we)       forwarded data value and one-cycle pulse
//   vcu_src                  source core of the current/last write
//
// Modports: slave = the arbiter, master = the environment (cores + VCU).
// -----------------------------------------------------------------------------
interface vcu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] p0_ctrl;
  logic              p0_ctrl_we;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_wdata_we;
  logic [DATA_W-1:0] p0_rdata;
  logic [DATA_W-1:0] p1_ctrl;
  logic              p1_ctrl_we;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_wdata_we;
  logic [DATA_W-1:0] p1_rdata;
  logic              vcu_ready;
  logic [DATA_W-1:0] vcu_reg_control;
  logic              vcu_reg_control_we;
  logic [DATA_W-1:0] vcu_reg_wdata;
  logic              vcu_reg_wdata_we;
  logic              vcu_src;

  modport slave (
    input  p0_ctrl, p0_ctrl_we, p0_wdata, p0_wdata_we,
    input  p1_ctrl, p1_ctrl_we, p1_wdata, p1_wdata_we,
    input  vcu_ready,
    output p0_rdata, p1_rdata,
    output vcu_reg_control, vcu_reg_control_we,
    output vcu_reg_wdata, vcu_reg_wdata_we, vcu_src
  );

  modport master (
    output p0_ctrl, p0_ctrl_we, p0_wdata, p0_wdata_we,
    output p1_ctrl, p1_ctrl_we, p1_wdata, p1_wdata_we,
    output vcu_ready,
    input  p0_rdata, p1_rdata,
    input  vcu_reg_control, vcu_reg_control_we,
    input  vcu_reg_wdata, vcu_reg_wdata_we, vcu_src
  );
endinterface

// File: rtl/vcu_arbiter.sv
// -----------------------------------------------------------------------------
// vcu_arbiter
// Shares one VCU register port between two CPU cores. Each core's control and
// wdata strobes are queued in a private 2-entry FIFO and drained round-robin,
// one write per cycle while vcu_ready is high. Each core gets a status word:
//   rdata[0] = tick timer expired, rdata[1] = sticky overflow,
//   rdata[2] = FIFO non-empty, upper bits zero.
//
// Ports:
//   clk    single clock, posedge
//   rst_n  asynchronous active-low reset
//   bus    vcu_arbiter_if.slave (core write ports, status, VCU port)
//
// Build option: VCU_ARB_TIMER_EN enables the per-core tick timers (reloaded by
// each wdata strobe). Without it no timer registers exist and rdata[0] reads 1.
// -----------------------------------------------------------------------------
module vcu_arbiter #(
  parameter int                DATA_W      = 32,
  parameter int                TICK_W      = 28,
  parameter logic [TICK_W-1:0] TICK_RELOAD = 28'h2FAF080
) (
  input logic           clk,
  input logic           rst_n,
  vcu_arbiter_if.slave  bus
);

  localparam logic KIND_CTRL  = 1'b0;
  localparam logic KIND_WDATA = 1'b1;

  typedef struct packed {
    logic              kind;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Per-core views of the interface so both cores share one description.
  logic [DATA_W-1:0] ctrl_i  [2];
  logic [DATA_W-1:0] wdata_i [2];
  logic [1:0]        ctrl_we_i;
  logic [1:0]        wdata_we_i;

  assign ctrl_i[0]  = bus.p0_ctrl;
  assign ctrl_i[1]  = bus.p1_ctrl;
  assign wdata_i[0] = bus.p0_wdata;
  assign wdata_i[1] = bus.p1_wdata;
  assign ctrl_we_i  = {bus.p1_ctrl_we,  bus.p0_ctrl_we};
  assign wdata_we_i = {bus.p1_wdata_we, bus.p0_wdata_we};

  // FIFO: slot 0 is always the head; a pop shifts slot 1 down.
  entry_t      fifo_q [2][2];
  entry_t      fifo_d [2][2];
  logic [1:0]  cnt_q  [2];
  logic [1:0]  cnt_d  [2];
  logic [1:0]  ovf_q, ovf_d;
  logic        last_q;

  logic [1:0]  ne;
  logic [1:0]  pop;
  logic        grant;
  logic        winner;
  entry_t      head;
  logic [1:0]  expired;

  logic [DATA_W-1:0] ctrl_q, wdata_q;
  logic              ctrl_we_q, wdata_we_q, src_q;

  // Round-robin: with both cores pending, the one not granted last time wins.
  always_comb begin
    ne[0]  = (cnt_q[0] != 2'd0);
    ne[1]  = (cnt_q[1] != 2'd0);
    grant  = bus.vcu_ready && (ne != 2'b00);
    winner = (ne == 2'b11) ? ~last_q : ne[1];
    pop    = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
    head   = fifo_q[winner][0];
  end

  // Pop first (frees a slot), then control push, then wdata push, each taking
  // the next free slot; whatever does not fit is dropped and flags overflow.
  always_comb begin
    logic [1:0] fill;
    logic       ovf_set;
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    fill    = 2'd0;
    ovf_set = 1'b0;
    fifo_d  = fifo_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    for (int c = 0; c < 2; c++) begin
      fill    = cnt_q[c] - {1'b0, pop[c]};
      ovf_set = 1'b0;
      if (pop[c]) fifo_d[c][0] = fifo_q[c][1];
      if (ctrl_we_i[c]) begin
        if (fill != 2'd2) begin
          fifo_d[c][fill[0]] = {KIND_CTRL, ctrl_i[c]};
          fill = fill + 2'd1;
        end else begin
          ovf_set = 1'b1;
        end
      end
      if (wdata_we_i[c]) begin
        if (fill != 2'd2) begin
          fifo_d[c][fill[0]] = {KIND_WDATA, wdata_i[c]};
          fill = fill + 2'd1;
        end else begin
          ovf_set = 1'b1;
        end
      end
      cnt_d[c] = fill;
      // Set beats clear when both happen in the same cycle.
      ovf_d[c] = ovf_set | (ovf_q[c] & ~(ctrl_we_i[c] & ctrl_i[c][DATA_W-1]));
    end
  end

  // NOTE: FIFO storage carries no reset; emptiness is defined by cnt_q alone,
  // so stale slot contents are never observed.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q[0]   <= 2'd0;
      cnt_q[1]   <= 2'd0;
      ovf_q      <= 2'b00;
      last_q     <= 1'b1;
      ctrl_q     <= '0;
      wdata_q    <= '0;
      ctrl_we_q  <= 1'b0;
      wdata_we_q <= 1'b0;
      src_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ctrl_we_q  <= grant && (head.kind == KIND_CTRL);
      wdata_we_q <= grant && (head.kind == KIND_WDATA);
      if (grant) begin
        src_q  <= winner;
        last_q <= winner;
        if (head.kind == KIND_WDATA) wdata_q <= head.data;
        else                         ctrl_q  <= head.data;
      end
    end
  end

`ifdef VCU_ARB_TIMER_EN
  // Tick timers: any sampled wdata strobe reloads, even if the write is
  // dropped; otherwise count down until the MSB (expired flag) sets, then hold.
  logic [TICK_W-1:0] tick_q [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q[0] <= TICK_RELOAD;
      tick_q[1] <= TICK_RELOAD;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (wdata_we_i[c])              tick_q[c] <= TICK_RELOAD;
        else if (!tick_q[c][TICK_W-1])  tick_q[c] <= tick_q[c] - TICK_W'(1);
      end
    end
  end

  assign expired = {tick_q[1][TICK_W-1], tick_q[0][TICK_W-1]};
`else
  assign expired = 2'b11;
`endif

  assign bus.p0_rdata = {{(DATA_W-3){1'b0}}, ne[0], ovf_q[0], expired[0]};
  assign bus.p1_rdata = {{(DATA_W-3){1'b0}}, ne[1], ovf_q[1], expired[1]};

  assign bus.vcu_reg_control    = ctrl_q;
  assign bus.vcu_reg_control_we = ctrl_we_q;
  assign bus.vcu_reg_wdata      = wdata_q;
  assign bus.vcu_reg_wdata_we   = wdata_we_q;
  assign bus.vcu_src            = src_q;

endmodule

// File: doc/vcu_arbiter.md
# vcu_arbiter

Shares one video control unit (VCU) register port between two sr_cpu_vc cores (p0, p1). Each core's control/wdata write strobes are queued in a private 2-entry FIFO and drained round-robin to the single VCU port, one write per cycle. Each core also gets its own status word on its vcu_reg_rdata input, including a per-core tick timer restarted by that core's wdata writes. Sits in top between both CPU instances and the VCU.

## Interface
- DATA_W, 32: VCU register width.
- TICK_W, 28: tick timer width; MSB is the expired flag.
- TICK_RELOAD, 28'h2FAF080: timer reload value. The bench overrides it to 28'h10.
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset. Asserts asynchronously; deassertion is synchronised externally.
- p0_ctrl, p1_ctrl  in  DATA_W  core control data.
- p0_ctrl_we, p1_ctrl_we  in  1  control write strobe.
- p0_wdata, p1_wdata  in  DATA_W  core write data.
- p0_wdata_we, p1_wdata_we  in  1  data write strobe.
- p0_rdata, p1_rdata  out  DATA_W  per-core status word.
- vcu_ready  in  1  VCU can accept a write at the next edge.
- vcu_reg_control  out  DATA_W  forwarded control value. Holds its last value.
- vcu_reg_control_we  out  1  one-cycle control write pulse.
- vcu_reg_wdata  out  DATA_W  forwarded data value. Holds its last value.
- vcu_reg_wdata_we  out  1  one-cycle data write pulse.
- vcu_src  out  1  source of the current/last write: 0 = p0, 1 = p1.

## Operation
- **FIFO entry format:** each core has a 2-entry FIFO. An entry is {kind, data}, where kind 0 = control and kind 1 = wdata.
- **Enqueue:**
  - Each strobe pushes one entry.
  - If ctrl_we and wdata_we are high in the same cycle, control is pushed first, then wdata. This needs 2 free slots.
- **Overflow:**
  - A push that finds the FIFO full is dropped and sets that core's sticky ovf flag.
  - With 1 free slot and a dual strobe, control is kept and wdata is dropped.
  - A pop in the same cycle frees a slot before the push is evaluated.
- **Arbitration:**
  - At each edge with vcu_ready=1 and at least one FIFO non-empty, the arbiter pops one entry and registers it onto the VCU port.
  - If both FIFOs are non-empty, the core not granted last time wins. The last-grant register resets to 1, so p0 wins first.
  - If only one FIFO is non-empty, that core wins and last-grant updates.
- **VCU output:**
  - A popped control entry loads vcu_reg_control and pulses vcu_reg_control_we.
  - A popped wdata entry loads vcu_reg_wdata and pulses vcu_reg_wdata_we.
  - vcu_src loads the winner. The two we pulses are never high together.
- **Tick timer (per core):**
  - Reloads to TICK_RELOAD in reset and whenever that core's wdata_we is sampled, even if the write is dropped.
  - Otherwise it decrements while MSB=0 and holds once MSB=1.
- **Status word:** rdata[0] = timer MSB (expired), rdata[1] = ovf, rdata[2] = FIFO non-empty, rdata[31:3] = 0.
- **Clearing ovf:** a sampled ctrl_we with ctrl[31]=1 clears that core's ovf. The same write is still enqueued normally. If an overflow occurs in the same cycle, set wins.

## Timing
- **Reset values:**
  - All VCU outputs and we pulses are 0; vcu_src = 0.
  - FIFOs are empty; ovf = 0; timers = TICK_RELOAD.
  - p0_rdata = p1_rdata = 0.
- **Latency:**
  - A strobe sampled at edge E is popped at the earliest edge E+1.
  - The we pulse is high in the cycle after E+1, which is 2 cycles from the strobe cycle.
  - Each extra competing entry adds 1 cycle.
- **Output pacing:** vcu_*_we is high for exactly one cycle per popped entry. Back-to-back pulses are allowed while vcu_ready stays 1.
- **vcu_ready=0:** no pop; we pulses are 0; data outputs hold.
- **rdata:** combinational from registered state. It reflects a push or pop one cycle after the edge.
- **Timer expiry:** the timer reaches MSB=1 TICK_RELOAD+1 edges after its reload.
- **Reset mid-operation:** FIFO contents are lost and any we pulse drops immediately.

## Configuration
- **VCU_ARB_TIMER_EN defined:** per-core tick timers are present as described above.
- **VCU_ARB_TIMER_EN undefined:** no timer registers; rdata[0] is tied to 1, so the timer always reads expired.

## Test plan
- Reset, then p0 ctrl_we with 32'h5 -> vcu_reg_control = 32'h5 with control_we high 2 cycles after the strobe; vcu_src = 0; p0_rdata[2] is 1 for one cycle.
- p0 and p1 each write wdata (32'hA1, 32'hB2) in the same cycle, vcu_ready=1 -> wdata_we pulses on 2 consecutive cycles, p0 (32'hA1) first then p1 (32'hB2); vcu_src 0 then 1.
- vcu_ready=0; p1 strobes ctrl+wdata together, then ctrl again -> third write dropped and p1_rdata = 32'h6. Raise ready -> exactly two pulses, control then wdata. Then p1 ctrl 32'h8000_0000 -> ovf clears.
- TICK_RELOAD=16; p0 wdata write at cycle 0 -> p0_rdata[0] is 0 until 17 edges after the reload, then 1 and holds. A new write at that point -> bit 0 is back to 0 next cycle.
- Assert rst_n low while both FIFOs are full and a pulse is in flight -> outputs 0 immediately and FIFOs empty after release.
- Build without VCU_ARB_TIMER_EN -> rdata[0] = 1 from reset onwards; arbitration results identical to the second scenario.
